// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the receiver), frame constants, parity rule.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } uart_state_e;

  // Named NUM_DATA_BITS because DATA_BITS is already the state name above.
  localparam int unsigned NUM_DATA_BITS = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  typedef logic [NUM_DATA_BITS-1:0] uart_byte_t;

  function automatic logic odd_parity(input uart_byte_t b);
    return ~^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; full/empty are registered flags.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rd_data_c = mem[rd_ptr];

  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  // Storage needs no reset; only the pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_n;
      full  <= (count_n == CNT_W'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, odd parity, one stop bit.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry holding FIFO in front of the FSM.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(NUM_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NUM_DATA_BITS - 1);

  uart_state_e       state_q, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [BIT_W-1:0]  bit_count, bit_n;
  uart_byte_t        shift_reg, shift_n;
  logic              parity, parity_n;
  logic              tx_n;
  logic              tx_done_n;
  logic              baud_last;
  logic              start_req;
  uart_byte_t        start_byte;

  assign baud_last = (baud_cnt == BAUD_LAST);

`ifdef UART_TX_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  uart_byte_t fifo_rd_data_c;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NUM_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (data_valid && data_ready),
    .wr_data   (data_in),
    .pop       (fifo_pop),
    .rd_data_c (fifo_rd_data_c),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Pop in IDLE, or on the last stop-bit cycle to chain frames with no idle gap.
  assign fifo_pop   = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP_BIT) && baud_last));
  assign start_req  = fifo_pop;
  assign start_byte = fifo_rd_data_c;
  assign data_ready = !fifo_full;
`else
  assign start_req  = data_valid && data_ready;
  assign start_byte = data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_ready <= 1'b1;
    end else begin
      data_ready <= (state_n == IDLE);
    end
  end

  logic unused_fifo_depth;
  assign unused_fifo_depth = ^FIFO_DEPTH;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_n  = state_q;
    baud_n   = baud_cnt;
    bit_n    = bit_count;
    shift_n  = shift_reg;
    parity_n = parity;
    if (state_q != IDLE) begin
      baud_n = baud_last ? '0 : baud_cnt + BAUD_W'(1);
    end
    case (state_q)
      IDLE: begin
        baud_n = '0;
        if (start_req) begin
          state_n  = START_BIT;
          shift_n  = start_byte;
          parity_n = odd_parity(start_byte);
        end
      end
      START_BIT: begin
        if (baud_last) begin
          state_n = DATA_BITS;
          bit_n   = '0;
        end
      end
      DATA_BITS: begin
        if (baud_last) begin
          shift_n = shift_reg >> 1;
          if (bit_count == BIT_LAST) begin
            state_n = PARITY_BIT;
          end else begin
            bit_n = bit_count + BIT_W'(1);
          end
        end
      end
      PARITY_BIT: begin
        if (baud_last) state_n = STOP_BIT;
      end
      STOP_BIT: begin
        if (baud_last) begin
          if (start_req) begin
            state_n  = START_BIT;
            shift_n  = start_byte;
            parity_n = odd_parity(start_byte);
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level and done pulse are decoded from next state so they can be registered.
  always_comb begin
    tx_n = IDLE_LVL;
    case (state_n)
      START_BIT:  tx_n = START_LVL;
      DATA_BITS:  tx_n = shift_n[0];
      PARITY_BIT: tx_n = parity_n;
      STOP_BIT:   tx_n = STOP_LVL;
      default:    tx_n = IDLE_LVL;
    endcase
    tx_done_n = (state_n == STOP_BIT) && (baud_n == BAUD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_cnt  <= '0;
      bit_count <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
      tx        <= IDLE_LVL;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_n;
      baud_cnt  <= baud_n;
      bit_count <= bit_n;
      shift_reg <= shift_n;
      parity    <= parity_n;
      tx        <= tx_n;
      tx_busy   <= (state_n != IDLE);
      tx_done   <= tx_done_n;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: line monitor decodes frames, tasks compare against a scoreboard.
module tb_uart_transmitter;

  localparam int CPB   = 2;
  localparam int FRAME = 11 * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic [10:0] bits;
    bit          stable;
    bit          done_ok;
    int          start_cyc;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  frame_t     rx_q[$];

  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: samples the line on falling edges and decodes complete frames.
  bit     in_frame   = 0;
  int     off        = 0;
  logic   cur_lvl;
  frame_t cur_f;
  int     done_cnt   = 0;
  int     stray_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0;
    end else begin
      if (tx_done === 1'b1) done_cnt++;
      if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1; off = 0;
          cur_f.bits = '0; cur_f.stable = 1; cur_f.done_ok = 1; cur_f.start_cyc = cyc;
        end else if (tx_done === 1'b1) begin
          stray_done++;
        end
      end
      if (in_frame) begin
        if (off % CPB == 0) cur_lvl = tx;
        else if (tx !== cur_lvl) cur_f.stable = 0;
        if (off % CPB == CPB - 1) cur_f.bits[off / CPB] = tx;
        if ((tx_done === 1'b1) != (off == FRAME - 1)) cur_f.done_ok = 0;
        if (off == FRAME - 1) begin
          rx_q.push_back(cur_f);
          in_frame = 0;
        end else begin
          off++;
        end
      end
    end
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    return {1'b1, ~(^b), b, 1'b0};
  endfunction

  // Call at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, output int acc, output bit ok);
    ok = 0; acc = 0;
    data_in = b; data_valid = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      if (data_ready === 1'b1) begin
        acc = cyc + 1; ok = 1;
        exp_q.push_back(b);
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic wait_frames(input int n, output bit ok);
    for (int k = 0; k < 3000 && rx_q.size() < n; k++) @(negedge clk);
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    #12;
    checks++;
    if ({tx, data_ready, tx_busy, tx_done} !== 4'b1100) begin
      failures++; $display("FAIL reset_values: got %b expected 1100", {tx, data_ready, tx_busy, tx_done});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, data_ready, tx_busy, tx_done} !== 4'b1100) begin
        failures++; $display("FAIL idle_cycle_%0d: got %b expected 1100", i, {tx, data_ready, tx_busy, tx_done});
      end
    end
  endtask

  task automatic test_frame_55;
    int acc; bit ok; frame_t f; logic [7:0] e;
    @(negedge clk);
    send_byte(8'h55, acc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL accept_55: got timeout expected accept"); end
    wait_frames(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL frame_55: got no frame expected one"); return; end
    f = rx_q.pop_front(); e = exp_q.pop_front();
    checks++;
    if (f.bits !== 11'b11010101010) begin
      failures++; $display("FAIL bits_55: got %b expected %b", f.bits, 11'b11010101010);
    end
    checks++;
    if (f.bits[8:1] !== e) begin failures++; $display("FAIL data_55: got %h expected %h", f.bits[8:1], e); end
    checks++;
    if ((^f.bits[9:1]) !== 1'b1) begin failures++; $display("FAIL parity_err_55: got even expected odd"); end
    checks++;
    if (f.start_cyc !== acc + LAT) begin
      failures++; $display("FAIL latency_55: got %0d expected %0d", f.start_cyc, acc + LAT);
    end
    checks++;
    if (!f.done_ok) begin failures++; $display("FAIL done_pulse_55: got misplaced expected on cycle %0d", FRAME); end
    checks++;
    if (!f.stable) begin failures++; $display("FAIL stable_55: got glitch expected stable bits"); end
  endtask

  task automatic test_parity;
    logic [7:0] vals [2];
    logic       pars [2];
    int acc; bit ok; frame_t f; logic [7:0] e;
    vals[0] = 8'h07; pars[0] = 1'b0;
    vals[1] = 8'h00; pars[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      send_byte(vals[i], acc, ok);
      wait_frames(1, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL frame_par_%0d: got no frame expected one", i); continue; end
      f = rx_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (f.bits[9] !== pars[i]) begin
        failures++; $display("FAIL parity_%h: got %b expected %b", vals[i], f.bits[9], pars[i]);
      end
      checks++;
      if (f.bits !== frame_bits(e)) begin
        failures++; $display("FAIL loop_%h: got %b expected %b", vals[i], f.bits, frame_bits(e));
      end
    end
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic test_busy_ignore;
    int acc; bit ok; frame_t f; logic [7:0] e;
    @(negedge clk);
    send_byte(8'hC3, acc, ok);
    repeat (6) @(negedge clk);
    checks++;
    if ({data_ready, tx_busy} !== 2'b01) begin
      failures++; $display("FAIL busy_flags: got %b expected 01", {data_ready, tx_busy});
    end
    data_in = 8'hA3; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_frames(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL frame_c3: got no frame expected one"); return; end
    f = rx_q.pop_front(); e = exp_q.pop_front();
    checks++;
    if (f.bits !== frame_bits(e)) begin failures++; $display("FAIL frame_c3_bits: got %b expected %b", f.bits, frame_bits(e)); end
    repeat (FRAME + 5) @(negedge clk);
    checks++;
    if (rx_q.size() !== 0 || tx !== 1'b1 || tx_busy !== 1'b0) begin
      failures++; $display("FAIL ignored_a3: got frames=%0d tx=%b busy=%b expected 0 1 0", rx_q.size(), tx, tx_busy);
    end
  endtask
`endif

  task automatic test_reset_mid;
    int acc; bit ok; int d0; frame_t f; logic [7:0] e;
    @(negedge clk);
    send_byte(8'h99, acc, ok);
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, data_ready, tx_busy, tx_done} !== 4'b1100) begin
      failures++; $display("FAIL async_reset: got %b expected 1100", {tx, data_ready, tx_busy, tx_done});
    end
    void'(exp_q.pop_back());
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (FRAME) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || rx_q.size() !== 0) begin
      failures++; $display("FAIL aborted_frame: got done=%0d frames=%0d expected done=%0d frames=0", done_cnt, rx_q.size(), d0);
    end
    send_byte(8'h3C, acc, ok);
    wait_frames(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL frame_3c: got no frame expected one"); return; end
    f = rx_q.pop_front(); e = exp_q.pop_front();
    checks++;
    if (f.bits !== frame_bits(e) || !f.done_ok || f.start_cyc !== acc + LAT) begin
      failures++; $display("FAIL frame_3c_clean: got %b done_ok=%0d start=%0d expected %b 1 %0d",
                           f.bits, f.done_ok, f.start_cyc, frame_bits(e), acc + LAT);
    end
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_back_to_back;
    logic [7:0] vals [5];
    int acc; bit ok; bit saw_low; int d0; int prev; frame_t f; logic [7:0] e;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    saw_low = 0; d0 = done_cnt; prev = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      send_byte(vals[i], acc, ok);
      if (data_ready === 1'b0) saw_low = 1;
      checks++;
      if (!ok) begin failures++; $display("FAIL push_%0d: got timeout expected accept", i); end
    end
    checks++;
    if (!saw_low) begin failures++; $display("FAIL ready_drop: got always high expected low when full"); end
    wait_frames(5, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_frames: got %0d expected 5", rx_q.size()); return; end
    for (int i = 0; i < 5; i++) begin
      f = rx_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (f.bits !== frame_bits(e)) begin failures++; $display("FAIL b2b_%0d: got %b expected %b", i, f.bits, frame_bits(e)); end
      if (i > 0) begin
        checks++;
        if (f.start_cyc - prev !== FRAME) begin
          failures++; $display("FAIL gap_%0d: got %0d expected %0d", i, f.start_cyc - prev, FRAME);
        end
      end
      prev = f.start_cyc;
    end
    checks++;
    if (done_cnt - d0 !== 5) begin failures++; $display("FAIL b2b_done: got %0d expected 5", done_cnt - d0); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame_55();
    test_parity();
`ifndef UART_TX_FIFO_EN
    test_busy_ignore();
`endif
    test_reset_mid();
`ifdef UART_TX_FIFO_EN
    test_back_to_back();
`endif
    checks++;
    if (stray_done !== 0) begin failures++; $display("FAIL stray_done: got %0d expected 0", stray_done); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
